// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: one full-adder slice and a carry flop, one operand bit per clock, LSB first.
// The sum and carry-out are registered on the completion edge and flagged by a one-cycle done pulse.
module serial_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             C_out
);

  // state | meaning
  // IDLE  | waiting for start, busy=0
  // RUN   | one sum bit per edge, busy=1
  // DONE  | done=1 for one cycle, start here chains the next add
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;

  logic             sum_bit, carry_d, last_bit;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    sum_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // the new bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
    res_d    = (res_sr_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= C_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_sr_q <= res_d;
          carry_q  <= carry_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            s_q     <= res_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= C_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign C_out = cout_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Scoreboard bench for serial_adder_4bit: the driver queues expected {C_out,s} per accepted start,
// and a negedge monitor pops and compares on every done pulse and checks that outputs hold otherwise.
module tb_serial_adder_4bit;
  logic       clk = 1'b0;
  logic       rst, start, C_in;
  logic [3:0] a, b;
  logic       busy, done, C_out;
  logic [3:0] s;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int cycle  = 0;
  logic [4:0] exp_q[$];
  int         done_t[$];
  logic [4:0] held = 5'd0;
  logic       prev_done = 1'b0;

  serial_adder_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .C_in(C_in),
    .busy(busy), .done(done), .s(s), .C_out(C_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      if (done) begin
        n_done++;
        done_t.push_back(cycle);
        check("no_double_done", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          held = exp_q.pop_front();
          check("result", {27'd0, C_out, s}, {27'd0, held});
        end
      end else begin
        check("hold", {27'd0, C_out, s}, {27'd0, held});
      end
    end
    prev_done = done;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      cyc();
      n++;
    end
    check({name, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input string name);
    start = 1'b1; a = ai; b = bi; C_in = ci;
    exp_q.push_back({1'b0, ai} + {1'b0, bi} + {4'd0, ci});
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_early_done"}, {31'd0, done}, 32'd0);
      cyc();
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    cyc();
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'hF; C_in = 1'b1;
    // reset held with start asserted
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {27'd0, C_out, s}, 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    cyc();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    cyc();

    run_op(4'b0101, 4'b0011, 1'b0, "basic");     // 8, carry 0
    run_op(4'b1111, 4'b0001, 1'b0, "carry1");    // 0, carry 1
    run_op(4'b1111, 4'b1111, 1'b1, "carry2");    // F, carry 1

    // start and operand changes during RUN are ignored
    nd = n_done;
    start = 1'b1; a = 4'b0010; b = 4'b0010; C_in = 1'b0;
    exp_q.push_back(5'b0_0100);
    cyc();
    for (int k = 0; k < 4; k++) begin
      start = 1'b1; a = 4'b1111; b = 4'(k * 5 + 3); C_in = k[0];
      cyc();
    end
    start = 1'b0;
    check("ign_done", {31'd0, done}, 32'd1);
    for (int k = 0; k < 6; k++) cyc();
    check("ign_one_pulse", n_done - nd, 32'd1);

    // reset in the middle of a run
    nd = n_done;
    start = 1'b1; a = 4'b1001; b = 4'b0111; C_in = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
    rst = 1'b1; held = 5'd0;
    cyc();
    rst = 1'b0;
    check("abort_sum", {27'd0, C_out, s}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 6; k++) cyc();
    check("abort_no_done", n_done - nd, 32'd0);
    run_op(4'b0001, 4'b0001, 1'b1, "post_abort"); // 3, carry 0

    // back-to-back with start held high
    done_t.delete();
    start = 1'b1; a = 4'd3; b = 4'd4; C_in = 1'b0;
    exp_q.push_back(5'd7);
    cyc();
    wait_done("b2b_first");
    a = 4'd8; b = 4'd8; C_in = 1'b0;
    exp_q.push_back(5'b1_0000);
    cyc();
    check("b2b_rerun_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_second");
    start = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    check("b2b_count", done_t.size(), 32'd2);
    if (done_t.size() == 2) check("b2b_spacing", done_t[1] - done_t[0], 32'd5);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_adder_4bit.md
Name: serial_adder_4bit

Overview:
- Bit-serial 4-bit adder, the addition counterpart of the team's ripple subtractor.
- Uses one full-adder slice and a carry flip-flop. It processes one operand bit per clock, LSB first.
- Instantiated where area matters more than latency, such as multi-cycle datapaths sharing one slice.
- Result and carry are registered and presented with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand/result width in bits. Legal range is WIDTH >= 1. Counter width is clog2(WIDTH+1).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request to begin an addition. Sampled only when busy=0.
- a  input  WIDTH  augend. Captured on the accepted start edge.
- b  input  WIDTH  addend. Captured on the accepted start edge.
- C_in  input  1  carry-in. Captured on the accepted start edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: s and C_out hold a new valid result.
- s  output  WIDTH  sum a+b+C_in, low WIDTH bits, registered.
- C_out  output  1  carry-out of the MSB, registered.

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-high, using ports clk and rst.
  - rst=1 at an edge forces: state=IDLE, busy=0, done=0, s=0, C_out=0, internal carry=0, bit counter=0, operand shift registers=0.
  - rst has priority over start and over any in-flight operation.
- States:
  - IDLE: busy=0. Sits here after reset.
  - RUN: busy=1. Serial add in progress.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE -> RUN, on an edge with start=1:
  - Latch a and b into shift registers.
  - Load the carry flip-flop with C_in.
  - Clear the bit counter.
- RUN, each edge:
  - Full-adder slice: sum bit = a_sr[0] ^ b_sr[0] ^ carry; carry' = majority(a_sr[0], b_sr[0], carry).
  - Shift the sum bit into the MSB end of the result shift register.
  - Shift a_sr and b_sr right by one.
  - Increment the counter.
- RUN -> DONE:
  - Happens on the edge that processes bit WIDTH-1.
  - On that same edge, s <= final result register and C_out <= final carry.
- DONE: always returns to IDLE after one cycle, unless start=1, in which case it goes to RUN.
  - start=1 while in DONE is accepted: back-to-back operation, no dead cycle.
- Latency:
  - Start accepted at edge T; busy=1 for edges T+1..T+WIDTH.
  - done=1 and the new s/C_out are visible in the cycle after edge T+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- Output hold:
  - s and C_out change only on the completion edge or on reset. Partial sums are never visible.
  - They hold their value through IDLE and through a subsequent RUN until that run completes.
- Input handling:
  - start while busy=1 is ignored.
  - a, b and C_in are don't-care except on the accepted start edge; changes during RUN have no effect.
- Arithmetic:
  - {C_out, s} = a + b + C_in, an exact (WIDTH+1)-bit unsigned result; there is no overflow case.
- Reset mid-RUN:
  - Aborts the operation; done is not pulsed and s/C_out clear to 0.
  - The next start after rst deasserts behaves as if from power-up.
- WIDTH=1:
  - RUN lasts one edge; done follows in the next cycle.

Test Plan:
- Reset: assert rst 2 cycles with start=1 held -> busy=0, done=0, s=0, C_out=0 throughout; no operation starts.
- Basic add: a=4'b0101, b=4'b0011, C_in=0, start pulse at T -> busy high T+1..T+4; done=1 after edge T+4 with s=4'b1000, C_out=0.
- Carry chain: a=4'b1111, b=4'b0001, C_in=0 -> s=4'b0000, C_out=1. Then a=4'b1111, b=4'b1111, C_in=1 -> s=4'b1111, C_out=1.
- Ignored inputs: start a=4'b0010, b=4'b0010; during busy, pulse start with a=4'b1111 and change a/b/C_in every cycle -> s=4'b0100, C_out=0, exactly one done pulse.
- Abort: start a=4'b1001, b=4'b0111; assert rst at edge T+2 -> s=0, C_out=0, no done pulse. A new start with a=4'b0001, b=4'b0001, C_in=1 -> s=4'b0011, C_out=0.
- Back-to-back: hold start=1 continuously with operands changed on each done cycle -> results (3+4=7, then 8+8=0 with C_out=1) spaced 5 cycles apart; done never high 2 consecutive cycles.
